// File: rtl/mips_pkg.sv
// Shared types and constants for the multicycle MIPS controller.
// Optional feature macro: MC_JUMP_EN (adds the j instruction and the JUMP state).
package mips_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned STATE_W = 4;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_e;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10
    } pc_src_e;

    typedef enum logic [1:0] {
        SRCB_REGB    = 2'b00,
        SRCB_FOUR    = 2'b01,
        SRCB_IMM     = 2'b10,
        SRCB_IMM_SH2 = 2'b11
    } alu_src_b_e;

    typedef enum logic [STATE_W-1:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMRD    = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWR    = 4'd6,
        S_EXECUTE  = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_ADDIEXEC = 4'd10,
        S_ADDIWB   = 4'd11
`ifdef MC_JUMP_EN
        ,
        S_JUMP     = 4'd12
`endif
    } state_e;

    // Control word produced by the state decoder, before mem_ready gating
    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       branch;
        pc_src_e    pc_src;
        logic       alu_src_a;
        alu_src_b_e alu_src_b;
        alu_op_e    alu_op;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       instr_done;
    } ctrl_t;

    // True for every opcode the controller sequences; anything else is a nop
    function automatic logic op_supported(logic [OP_W-1:0] op);
        logic ok;
        ok = (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_ADDI) ||
             (op == OP_LW) || (op == OP_SW);
`ifdef MC_JUMP_EN
        ok = ok || (op == OP_J);
`endif
        return ok;
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath/memory bundle: opcode, memory handshake and all control lines.
interface multicycle_controller_if;
    import mips_pkg::*;

    logic [OP_W-1:0] op;
    logic            mem_ready;
    logic            mem_req;
    logic            MemWrite;
    logic            IorD;
    logic            IRWrite;
    logic            PCWrite;
    logic            Branch;
    logic [1:0]      PCSrc;
    logic            ALUSrcA;
    logic [1:0]      ALUSrcB;
    logic [1:0]      ALUOp;
    logic            RegDst;
    logic            MemtoReg;
    logic            RegWrite;
    logic            instr_done;
    logic            illegal_op;

    // Controller side
    modport master (
        input  op, mem_ready,
        output mem_req, MemWrite, IorD, IRWrite, PCWrite, Branch, PCSrc,
               ALUSrcA, ALUSrcB, ALUOp, RegDst, MemtoReg, RegWrite,
               instr_done, illegal_op
    );

    // Datapath / memory side
    modport slave (
        output op, mem_ready,
        input  mem_req, MemWrite, IorD, IRWrite, PCWrite, Branch, PCSrc,
               ALUSrcA, ALUSrcB, ALUOp, RegDst, MemtoReg, RegWrite,
               instr_done, illegal_op
    );

endinterface

// File: rtl/mc_state_decoder.sv
// Pure state-to-control-word decode (Moore outputs, no handshake gating).
// Optional feature macro: MC_JUMP_EN.
module mc_state_decoder
    import mips_pkg::*;
(
    input  state_e state,
    output ctrl_t  ctrl
);

    // Every field defaults to 0; each state raises only what it needs
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_req   = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH2;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b1;
            end
            S_MEMWB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_req    = 1'b1;
                ctrl.iord       = 1'b1;
                ctrl.mem_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_dst    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_op     = ALU_SUB;
                ctrl.pc_src     = PCSRC_ALUOUT;
                ctrl.branch     = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_ADDIEXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_ADDIWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
`ifdef MC_JUMP_EN
            S_JUMP: begin
                ctrl.pc_src     = PCSRC_JUMP;
                ctrl.pc_write   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
`endif
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS sequencing controller: state register, next-state logic and
// mem_ready gating around the state decoder.
// Optional feature macro: MC_JUMP_EN (decode op 000010 into the JUMP state).
module multicycle_controller
    import mips_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    multicycle_controller_if.master bus
);

    state_e state;
    ctrl_t  ctrl;

    mc_state_decoder u_decoder (
        .state (state),
        .ctrl  (ctrl)
    );

    // State register and next-state selection; memory states stall on mem_ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_RESET;
        end else begin
            case (state)
                S_RESET:    state <= S_FETCH;
                S_FETCH:    if (bus.mem_ready) state <= S_DECODE;
                S_DECODE: begin
                    case (bus.op)
                        OP_LW, OP_SW: state <= S_MEMADR;
                        OP_RTYPE:     state <= S_EXECUTE;
                        OP_BEQ:       state <= S_BRANCH;
                        OP_ADDI:      state <= S_ADDIEXEC;
`ifdef MC_JUMP_EN
                        OP_J:         state <= S_JUMP;
`endif
                        default:      state <= S_FETCH;
                    endcase
                end
                S_MEMADR:   state <= (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:    if (bus.mem_ready) state <= S_MEMWB;
                S_MEMWB:    state <= S_FETCH;
                S_MEMWR:    if (bus.mem_ready) state <= S_FETCH;
                S_EXECUTE:  state <= S_ALUWB;
                S_ALUWB:    state <= S_FETCH;
                S_BRANCH:   state <= S_FETCH;
                S_ADDIEXEC: state <= S_ADDIWB;
                S_ADDIWB:   state <= S_FETCH;
`ifdef MC_JUMP_EN
                S_JUMP:     state <= S_FETCH;
`endif
                default:    state <= S_RESET;
            endcase
        end
    end

    // Drive the bus; fetch writes and the store's retire wait for the memory
    always_comb begin
        bus.mem_req    = ctrl.mem_req;
        bus.MemWrite   = ctrl.mem_write;
        bus.IorD       = ctrl.iord;
        bus.IRWrite    = ctrl.ir_write;
        bus.PCWrite    = ctrl.pc_write;
        bus.Branch     = ctrl.branch;
        bus.PCSrc      = 2'(ctrl.pc_src);
        bus.ALUSrcA    = ctrl.alu_src_a;
        bus.ALUSrcB    = 2'(ctrl.alu_src_b);
        bus.ALUOp      = 2'(ctrl.alu_op);
        bus.RegDst     = ctrl.reg_dst;
        bus.MemtoReg   = ctrl.mem_to_reg;
        bus.RegWrite   = ctrl.reg_write;
        bus.instr_done = ctrl.instr_done;
        bus.illegal_op = (state == S_DECODE) && !op_supported(bus.op);
        if (state == S_FETCH) begin
            bus.IRWrite = ctrl.ir_write & bus.mem_ready;
            bus.PCWrite = ctrl.pc_write & bus.mem_ready;
        end
        if (state == S_MEMWR) begin
            bus.instr_done = ctrl.instr_done & bus.mem_ready;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: table vectors, hand-written
// corner sequences and randomized instruction streams against a phase model.
module tb_multicycle_controller;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    multicycle_controller_if bus();

    multicycle_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       branch;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       instr_done;
        logic       illegal_op;
    } obs_t;

    typedef enum int {
        PH_IF, PH_ID, PH_ADDR, PH_LOAD, PH_LWB, PH_STORE,
        PH_EX, PH_RWB, PH_BR, PH_IEX, PH_IWB, PH_JMP
    } ph_e;

    typedef struct {
        logic [5:0] op;
        int         fw;
        int         dw;
        int         lat;   // 0 means illegal (no retire)
        int         regw;
        int         memw;
    } vec_t;

    function automatic obs_t sample();
        obs_t s;
        s.mem_req    = bus.mem_req;
        s.mem_write  = bus.MemWrite;
        s.iord       = bus.IorD;
        s.ir_write   = bus.IRWrite;
        s.pc_write   = bus.PCWrite;
        s.branch     = bus.Branch;
        s.pc_src     = bus.PCSrc;
        s.alu_src_a  = bus.ALUSrcA;
        s.alu_src_b  = bus.ALUSrcB;
        s.alu_op     = bus.ALUOp;
        s.reg_dst    = bus.RegDst;
        s.mem_to_reg = bus.MemtoReg;
        s.reg_write  = bus.RegWrite;
        s.instr_done = bus.instr_done;
        s.illegal_op = bus.illegal_op;
        return s;
    endfunction

    function automatic bit legal(logic [5:0] o);
        bit ok;
        ok = (o == 6'b000000) || (o == 6'b000100) || (o == 6'b001000) ||
             (o == 6'b100011) || (o == 6'b101011);
`ifdef MC_JUMP_EN
        ok = ok || (o == 6'b000010);
`endif
        return ok;
    endfunction

    // Expected control lines for one cycle of an instruction phase
    function automatic obs_t expect_of(ph_e p, logic rdy, logic [5:0] o);
        obs_t e;
        e = '0;
        case (p)
            PH_IF:    begin e.mem_req = 1; e.alu_src_b = 2'b01; e.ir_write = rdy; e.pc_write = rdy; end
            PH_ID:    begin e.alu_src_b = 2'b11; e.illegal_op = !legal(o); end
            PH_ADDR:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
            PH_LOAD:  begin e.mem_req = 1; e.iord = 1; end
            PH_LWB:   begin e.mem_to_reg = 1; e.reg_write = 1; e.instr_done = 1; end
            PH_STORE: begin e.mem_req = 1; e.iord = 1; e.mem_write = 1; e.instr_done = rdy; end
            PH_EX:    begin e.alu_src_a = 1; e.alu_op = 2'b10; end
            PH_RWB:   begin e.reg_dst = 1; e.reg_write = 1; e.instr_done = 1; end
            PH_BR:    begin e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_src = 2'b01; e.branch = 1; e.instr_done = 1; end
            PH_IEX:   begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
            PH_IWB:   begin e.reg_write = 1; e.instr_done = 1; end
            PH_JMP:   begin e.pc_src = 2'b10; e.pc_write = 1; e.instr_done = 1; end
            default:  e = '0;
        endcase
        return e;
    endfunction

    task automatic check_obs(input string tag, input obs_t got, input obs_t exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One cycle: called at posedge+1, drives inputs, checks, advances to next posedge+1
    task automatic step(input ph_e p, input logic rdy, input logic [5:0] o, output obs_t got);
        bus.op        = (p == PH_IF) ? 6'($urandom) : o;
        bus.mem_ready = rdy;
        #2;
        got = sample();
        check_obs($sformatf("op%b_ph%0d", o, p), got, expect_of(p, rdy, o));
        @(posedge clk);
        #1;
    endtask

    // Run one instruction from its first FETCH cycle; returns observed milestones
    task automatic run_instr(input logic [5:0] o, input int fw, input int dw,
                             output int done_at, output int ill_at,
                             output int regw, output int memw, output int irw);
        ph_e  plist[$];
        int   waits[$];
        int   cyc;
        bit   is_mem;
        logic rdy;
        obs_t got;
        plist.push_back(PH_IF); waits.push_back(fw);
        plist.push_back(PH_ID); waits.push_back(0);
        if (legal(o)) begin
            case (o)
                6'b100011: begin
                    plist.push_back(PH_ADDR); waits.push_back(0);
                    plist.push_back(PH_LOAD); waits.push_back(dw);
                    plist.push_back(PH_LWB);  waits.push_back(0);
                end
                6'b101011: begin
                    plist.push_back(PH_ADDR);  waits.push_back(0);
                    plist.push_back(PH_STORE); waits.push_back(dw);
                end
                6'b000000: begin
                    plist.push_back(PH_EX);  waits.push_back(0);
                    plist.push_back(PH_RWB); waits.push_back(0);
                end
                6'b000100: begin plist.push_back(PH_BR); waits.push_back(0); end
                6'b001000: begin
                    plist.push_back(PH_IEX); waits.push_back(0);
                    plist.push_back(PH_IWB); waits.push_back(0);
                end
                default: begin plist.push_back(PH_JMP); waits.push_back(0); end
            endcase
        end
        cyc = 0; done_at = -1; ill_at = -1; regw = 0; memw = 0; irw = 0;
        foreach (plist[i]) begin
            for (int k = 0; k <= waits[i]; k++) begin
                is_mem = (plist[i] == PH_IF) || (plist[i] == PH_LOAD) || (plist[i] == PH_STORE);
                rdy    = is_mem ? logic'(k == waits[i]) : 1'($urandom);
                cyc++;
                step(plist[i], rdy, o, got);
                if (got.instr_done && done_at < 0) done_at = cyc;
                if (got.illegal_op && ill_at < 0) ill_at = cyc;
                regw += int'(got.reg_write);
                memw += int'(got.mem_write);
                irw  += int'(got.ir_write);
            end
        end
    endtask

    // Run an instruction and check its aggregate behaviour
    task automatic do_instr(input logic [5:0] o, input int fw, input int dw,
                            input int lat, input int regw_exp, input int memw_exp);
        int done_at, ill_at, regw, memw, irw;
        run_instr(o, fw, dw, done_at, ill_at, regw, memw, irw);
        if (lat == 0) begin
            check_int($sformatf("illegal_at op%b", o), ill_at, 2 + fw);
            check_int($sformatf("no_retire op%b", o), done_at, -1);
        end else begin
            check_int($sformatf("latency op%b fw%0d dw%0d", o, fw, dw), done_at, lat);
            check_int($sformatf("no_illegal op%b", o), ill_at, -1);
        end
        check_int($sformatf("regwrite_cycles op%b", o), regw, regw_exp);
        check_int($sformatf("memwrite_cycles op%b", o), memw, memw_exp);
        check_int($sformatf("irwrite_cycles op%b", o), irw, 1);
    endtask

    // Spec-level latency model: base cycles plus one per wait state
    function automatic int model_lat(logic [5:0] o, int fw, int dw);
        if (!legal(o)) return 0;
        case (o)
            6'b100011: return 5 + fw + dw;
            6'b101011: return 4 + fw + dw;
            6'b000000: return 4 + fw;
            6'b001000: return 4 + fw;
            default:   return 3 + fw;
        endcase
    endfunction

    vec_t vecs[12];
    logic [5:0] pool[8];

    initial begin
        obs_t got;
        logic [5:0] o;
        int fw, dw;

        vecs[0]  = '{6'b100011, 0, 0, 5, 1, 0};
        vecs[1]  = '{6'b100011, 3, 0, 8, 1, 0};
        vecs[2]  = '{6'b000100, 0, 0, 3, 0, 0};
        vecs[3]  = '{6'b101011, 0, 2, 6, 0, 3};
        vecs[4]  = '{6'b000000, 0, 0, 4, 1, 0};
        vecs[5]  = '{6'b001000, 0, 0, 4, 1, 0};
        vecs[6]  = '{6'b101011, 0, 0, 4, 0, 1};
        vecs[7]  = '{6'b100011, 0, 2, 7, 1, 0};
        vecs[8]  = '{6'b111111, 0, 0, 0, 0, 0};
`ifdef MC_JUMP_EN
        vecs[9]  = '{6'b000010, 0, 0, 3, 0, 0};
`else
        vecs[9]  = '{6'b000010, 0, 0, 0, 0, 0};
`endif
        vecs[10] = '{6'b000101, 1, 0, 0, 0, 0};
        vecs[11] = '{6'b000100, 1, 0, 4, 0, 0};

        pool = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                 6'b001000, 6'b000010, 6'b111111, 6'b001100};

        // Reset: all outputs low while held, even with mem_ready high
        bus.op = 6'b100011;
        bus.mem_ready = 1'b1;
        #3;
        check_obs("reset_hold", sample(), '0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check_obs("reset_state_after_release", sample(), '0);
        @(posedge clk);
        #1;

        // Directed table
        foreach (vecs[i])
            do_instr(vecs[i].op, vecs[i].fw, vecs[i].dw, vecs[i].lat, vecs[i].regw, vecs[i].memw);

        // Async reset in the middle of a stalled load
        step(PH_IF,   1'b1, 6'b100011, got);
        step(PH_ID,   1'b1, 6'b100011, got);
        step(PH_ADDR, 1'b0, 6'b100011, got);
        step(PH_LOAD, 1'b0, 6'b100011, got);
        bus.mem_ready = 1'b0;
        #1;
        check_obs("memrd_before_reset", sample(), expect_of(PH_LOAD, 1'b0, 6'b100011));
        rst_n = 1'b0;
        #1;
        check_obs("reset_mid_memrd", sample(), '0);
        check_int("mem_req_drop", int'(bus.mem_req), 0);
        @(posedge clk);
        #1;
        check_obs("reset_held_edge", sample(), '0);
        rst_n = 1'b1;
        bus.mem_ready = 1'b1;
        #1;
        check_obs("reset_released", sample(), '0);
        @(posedge clk);
        #1;
        do_instr(6'b100011, 0, 0, 5, 1, 0);

        // Randomized instruction stream with random wait states
        for (int n = 0; n < 150; n++) begin
            o  = pool[$urandom_range(0, 7)];
            if ($urandom_range(0, 5) == 0) o = 6'($urandom);
            fw = $urandom_range(0, 3);
            dw = $urandom_range(0, 3);
            do_instr(o, fw, dw, model_lat(o, fw, dw),
                     (o == 6'b100011 || o == 6'b000000 || o == 6'b001000) ? 1 : 0,
                     (o == 6'b101011) ? dw + 1 : 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
